// File: rtl/gnrl_xmon_defs.sv
// gnrl_xmon_defs: state encodings and index-width helpers shared by the
// gnrl_xmonitor interface, top level and per-channel checker.
`ifndef GNRL_XMON_DEFS_SV
`define GNRL_XMON_DEFS_SV

// Width of an index selecting one of n items, never narrower than one bit
`define XMON_IDX_W(n) (((n) > 1) ? $clog2(n) : 1)

package gnrl_xmon_defs;

  localparam logic [1:0] XMON_WARM    = 2'd0;
  localparam logic [1:0] XMON_ARMED   = 2'd1;
  localparam logic [1:0] XMON_TRIPPED = 2'd2;

  // Same rule as XMON_IDX_W, usable where macro ordering is awkward
  function automatic int xmon_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/gnrl_xmonitor_if.sv
// gnrl_xmonitor_if: channel inputs and report outputs of the X monitor.
// The master side drives the monitored channels, the slave side is the monitor.
interface gnrl_xmonitor_if
  import gnrl_xmon_defs::*;
#(
  parameter int CH    = 4,
  parameter int DW    = 32,
  parameter int CNT_W = 8,
  parameter int TS_W  = 32
);

  localparam int IDX_W = xmon_idx_w(CH);

  logic                  i_en;
  logic [CH-1:0]         i_vld;
  logic [CH*DW-1:0]      i_dat;
  logic                  i_clr;
  logic                  o_err;
  logic [CH-1:0]         o_err_ch;
  logic [IDX_W-1:0]      o_first_ch;
  logic [TS_W-1:0]       o_first_ts;
  logic [CH*CNT_W-1:0]   o_xcnt;
  logic [1:0]            o_state;

  modport master (
    output i_en, i_vld, i_dat, i_clr,
    input  o_err, o_err_ch, o_first_ch, o_first_ts, o_xcnt, o_state
  );

  modport slave (
    input  i_en, i_vld, i_dat, i_clr,
    output o_err, o_err_ch, o_first_ch, o_first_ts, o_xcnt, o_state
  );

endinterface

// File: rtl/gnrl_xmon_chan.sv
// gnrl_xmon_chan: one monitored channel. Flags a valid word containing any
// X or Z bit, and keeps a sticky violation flag plus a saturating hit count.
module gnrl_xmon_chan #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [DW-1:0]    i_dat,
  input  logic             i_cnt_en,
  input  logic             i_clr,
  output logic             o_hit,
  output logic             o_err,
  output logic [CNT_W-1:0] o_xcnt
);

  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  // Any unknown or floating bit in a valid word is a hit
  assign o_hit = i_vld & $isunknown(i_dat);

  // Sticky flag and count; the count holds at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (i_cnt_en && o_hit) begin
      r_err <= 1'b1;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_err  = r_err;
  assign o_xcnt = r_cnt;

endmodule

// File: rtl/gnrl_xmonitor.sv
// gnrl_xmonitor: multi-channel X/Z monitor with a warm-up window, capture of
// the first violating channel and timestamp, and per-channel saturating counts.
// Simulation-only checker: with FPGA_SOURCE defined the logic is removed and
// all outputs are tied low. Defining GNRL_XMONITOR_FATAL_EN additionally aborts
// the simulation on the first violation seen while armed.
module gnrl_xmonitor
  import gnrl_xmon_defs::*;
#(
  parameter int CH     = 4,
  parameter int DW     = 32,
  parameter int CNT_W  = 8,
  parameter int WARMUP = 16,
  parameter int TS_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  gnrl_xmonitor_if.slave    io_bus
);

  localparam int               IDX_W      = xmon_idx_w(CH);
  localparam int               WARM_W     = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [1:0]       INIT_STATE = (WARMUP == 0) ? XMON_ARMED : XMON_WARM;

`ifndef FPGA_SOURCE

  logic [1:0]         r_state;
  logic [WARM_W-1:0]  r_warmCnt;
  logic [TS_W-1:0]    r_ts;
  logic               r_err;
  logic [IDX_W-1:0]   r_firstCh;
  logic [TS_W-1:0]    r_firstTs;
  logic [CH-1:0]      w_hit;
  logic [CH-1:0]      w_errCh;
  logic [CH*CNT_W-1:0] w_xcnt;
  logic               w_cntEn;
  logic               w_anyHit;
  logic [IDX_W-1:0]   w_lowIdx;

  // Counting is only live once armed, and a clear in the same cycle discards hits
  assign w_cntEn  = io_bus.i_en & ~io_bus.i_clr & (r_state != XMON_WARM);
  assign w_anyHit = |w_hit;

  for (genvar k = 0; k < CH; k++) begin : g_chan
    gnrl_xmon_chan #(
      .DW    (DW),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_vld    (io_bus.i_vld[k]),
      .i_dat    (io_bus.i_dat[k*DW +: DW]),
      .i_cnt_en (w_cntEn),
      .i_clr    (io_bus.i_clr),
      .o_hit    (w_hit[k]),
      .o_err    (w_errCh[k]),
      .o_xcnt   (w_xcnt[k*CNT_W +: CNT_W])
    );
  end

  // Lowest-numbered hitting channel wins the first-violation report
  always_comb begin
    w_lowIdx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_hit[i]) w_lowIdx = IDX_W'(i);
    end
  end

  // Free-running timestamp, independent of enable, parks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else if (r_ts != {TS_W{1'b1}}) r_ts <= r_ts + 1'b1;
  end

  // Warm-up / armed / tripped sequencing with first-violation capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT_STATE;
      r_warmCnt <= '0;
      r_err     <= 1'b0;
      r_firstCh <= '0;
      r_firstTs <= '0;
    end else if (io_bus.i_clr) begin
      r_state   <= INIT_STATE;
      r_warmCnt <= '0;
      r_err     <= 1'b0;
      r_firstCh <= '0;
      r_firstTs <= '0;
    end else if (io_bus.i_en) begin
      case (r_state)
        XMON_WARM: begin
          if (r_warmCnt == WARM_LAST) r_state <= XMON_ARMED;
          else r_warmCnt <= r_warmCnt + 1'b1;
        end
        XMON_ARMED: begin
          if (w_anyHit) begin
            r_state   <= XMON_TRIPPED;
            r_err     <= 1'b1;
            r_firstCh <= w_lowIdx;
            r_firstTs <= r_ts;
          end
        end
        XMON_TRIPPED: begin
        end
        default: r_state <= INIT_STATE;
      endcase
    end
  end

  assign io_bus.o_err      = r_err;
  assign io_bus.o_err_ch   = w_errCh;
  assign io_bus.o_first_ch = r_firstCh;
  assign io_bus.o_first_ts = r_firstTs;
  assign io_bus.o_xcnt     = w_xcnt;
  assign io_bus.o_state    = r_state;

`ifdef GNRL_XMONITOR_FATAL_EN
  logic w_trip;
  logic r_tripEvt;

  assign w_trip = io_bus.i_en & ~io_bus.i_clr & (r_state == XMON_ARMED) & w_anyHit;

  // One-cycle marker of the trip edge so the abort sees the captured values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tripEvt <= 1'b0;
    else r_tripEvt <= w_trip;
  end

  // Abort the run once the first violation has been latched
  always @(posedge r_tripEvt) begin
    $fatal(1, "gnrl_xmonitor: X/Z on channel %0d at timestamp %0d", r_firstCh, r_firstTs);
  end
`endif

`else

  assign io_bus.o_err      = 1'b0;
  assign io_bus.o_err_ch   = '0;
  assign io_bus.o_first_ch = '0;
  assign io_bus.o_first_ts = '0;
  assign io_bus.o_xcnt     = '0;
  assign io_bus.o_state    = 2'd0;

`endif

endmodule
